// File: rtl/ahb_led_pkg.sv
// Shared definitions for the AHB-Lite LED/PWM controller: register word
// offsets (HADDR[7:2]), CTRL bit positions and the latched data-phase record.
package ahb_led_pkg;

  localparam logic [5:0] IDX_CTRL  = 6'd0;
  localparam logic [5:0] IDX_OUT   = 6'd1;
  localparam logic [5:0] IDX_PWMEN = 6'd2;
  localparam logic [5:0] IDX_PRESC = 6'd3;
  localparam logic [5:0] IDX_DUTY0 = 6'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLINK = 1;

  // Address-phase information carried into the data phase
  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [5:0] idx;
  } ahb_dphase_t;

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared PWM timebase: prescaler producing tick, PWM counter advancing on
// tick and pulsing wrap at rollover, and a blink phase toggling on each wrap.
module led_pwm_timebase #(
  parameter int PRESC_W = 16,
  parameter int PWM_W   = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               presc_wr,
  output logic [PWM_W-1:0]   pwm_cnt,
  output logic               tick,
  output logic               wrap,
  output logic               phase
);

  logic [PRESC_W-1:0] presc_cnt;

  // tick compares against the current PRESC, so a write landing on a tick
  // cycle still lets the counter advance with the old divider
  assign tick = en & (presc_cnt == presc);
  assign wrap = tick & (&pwm_cnt);

  // Counters run only while enabled; disabling parks everything at 0
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      phase     <= 1'b0;
    end else if (!en) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      phase     <= 1'b0;
    end else begin
      presc_cnt <= (presc_wr || tick) ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) phase   <= ~phase;
    end
  end

endmodule

// File: rtl/ahblite_led_pwm.sv
// AHB-Lite slave LED controller: zero-wait register file, per-channel static
// or PWM drive, global enable and blink gate, registered LED outputs.
module ahblite_led_pwm
  import ahb_led_pkg::*;
#(
  parameter int N_LED   = 8,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [3:0]       HPROT,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic             HRESP,
  output logic [N_LED-1:0] led_out
);

  ahb_dphase_t dp;
  logic        acc;
  logic        wr_en;

  logic [1:0]                  ctrl;
  logic [N_LED-1:0]            out_r;
  logic [N_LED-1:0]            pwmen;
  logic [PRESC_W-1:0]          presc;
  logic [N_LED-1:0][PWM_W-1:0] duty;

  logic [PWM_W-1:0] pwm_cnt;
  logic             tb_tick, tb_wrap, phase;
  logic             presc_wr;
  logic             gate;
  logic [N_LED-1:0] raw;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign acc   = HSEL & HTRANS[1] & HREADY;
  assign wr_en = dp.vld & dp.wr;

  // Latch the address phase; hold it while another slave stalls the bus
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    dp <= '0;
    else if (HREADY) dp <= '{vld: acc, wr: HWRITE, idx: HADDR[7:2]};
  end

  // Control registers commit from HWDATA at the end of the write data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl  <= '0;
      out_r <= '0;
      pwmen <= '0;
      presc <= '0;
    end else if (wr_en) begin
      case (dp.idx)
        IDX_CTRL:  ctrl  <= HWDATA[1:0];
        IDX_OUT:   out_r <= HWDATA[N_LED-1:0];
        IDX_PWMEN: pwmen <= HWDATA[N_LED-1:0];
        IDX_PRESC: presc <= HWDATA[PRESC_W-1:0];
        default: ;
      endcase
    end
  end

  // Duty registers occupy consecutive words from IDX_DUTY0
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      duty <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++)
        if (wr_en && dp.idx == 6'(IDX_DUTY0 + i)) duty[i] <= HWDATA[PWM_W-1:0];
    end
  end

  // Zero-wait read mux; anything but a valid read data phase returns 0
  always_comb begin
    HRDATA = '0;
    if (dp.vld && !dp.wr) begin
      case (dp.idx)
        IDX_CTRL:  HRDATA = 32'(ctrl);
        IDX_OUT:   HRDATA = 32'(out_r);
        IDX_PWMEN: HRDATA = 32'(pwmen);
        IDX_PRESC: HRDATA = 32'(presc);
        default: begin
          for (int i = 0; i < N_LED; i++)
            if (dp.idx == 6'(IDX_DUTY0 + i)) HRDATA = 32'(duty[i]);
        end
      endcase
    end
  end

  assign presc_wr = wr_en && (dp.idx == IDX_PRESC);

  led_pwm_timebase #(
    .PRESC_W (PRESC_W),
    .PWM_W   (PWM_W)
  ) u_tb (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .en       (ctrl[CTRL_EN]),
    .presc    (presc),
    .presc_wr (presc_wr),
    .pwm_cnt  (pwm_cnt),
    .tick     (tb_tick),
    .wrap     (tb_wrap),
    .phase    (phase)
  );

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    assign raw[i] = pwmen[i] ? (pwm_cnt < duty[i]) : out_r[i];
  end

  assign gate = ctrl[CTRL_EN] & (ctrl[CTRL_BLINK] ? phase : 1'b1);

  // Registered LED drive, one cycle behind counter/register state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) led_out <= '0;
    else          led_out <= {N_LED{gate}} & raw;
  end

  // Bus fields this slave does not decode
  logic unused_bits;
  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:8], HADDR[1:0], HTRANS[0],
                         HWDATA, tb_tick, tb_wrap};

endmodule

// File: tb/tb_ahblite_led_pwm.sv
// Directed + randomized bench for ahblite_led_pwm with a register/time model.
module tb_ahblite_led_pwm;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [7:0]  led_out;

  ahblite_led_pwm #(.N_LED(8), .PWM_W(8), .PRESC_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .led_out(led_out)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  // Model: register contents, prescaler position and total ticks since enable
  int     m_ctrl, m_out, m_pwmen, m_presc;
  int     m_duty [8];
  int     m_pc;
  longint m_ticks;
  logic [7:0] m_led;
  bit     m_dpv, m_dpw;
  int     m_dpi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_rd(input int idx);
    case (idx)
      0: return m_ctrl;
      1: return m_out;
      2: return m_pwmen;
      3: return m_presc;
      default: return (idx >= 4 && idx < 12) ? m_duty[idx-4] : 0;
    endcase
  endfunction

  task automatic model_wr(input int idx, input logic [31:0] d);
    case (idx)
      0: m_ctrl  = int'(d & 32'h3);
      1: m_out   = int'(d & 32'hFF);
      2: m_pwmen = int'(d & 32'hFF);
      3: m_presc = int'(d & 32'hFFFF);
      default: if (idx >= 4 && idx < 12) m_duty[idx-4] = int'(d & 32'hFF);
    endcase
  endtask

  task automatic model_clear();
    m_ctrl = 0; m_out = 0; m_pwmen = 0; m_presc = 0;
    foreach (m_duty[i]) m_duty[i] = 0;
    m_pc = 0; m_ticks = 0; m_led = '0; m_dpv = 0; m_dpw = 0; m_dpi = 0;
  endtask

  // One clock: predict from spec rules, advance, then compare led_out
  task automatic cycle();
    bit en, blink, ph, tick, raw, pw;
    int pwm, npc;
    longint nt;
    logic [7:0] nled;
    en    = m_ctrl[0];
    blink = m_ctrl[1];
    pwm   = int'(m_ticks % 256);
    ph    = ((m_ticks / 256) % 2) == 1;
    for (int i = 0; i < 8; i++) begin
      raw = m_pwmen[i] ? (pwm < m_duty[i]) : m_out[i];
      nled[i] = en & (blink ? ph : 1'b1) & raw;
    end
    tick = en && (m_pc == m_presc);
    pw   = m_dpv && m_dpw && (m_dpi == 3);
    if (!en) begin
      npc = 0; nt = 0;
    end else begin
      npc = (pw || tick) ? 0 : m_pc + 1;
      nt  = m_ticks + (tick ? 1 : 0);
    end
    if (m_dpv && m_dpw) model_wr(m_dpi, HWDATA);
    m_dpv = HSEL && HTRANS[1] && HREADY;
    m_dpw = HWRITE;
    m_dpi = int'(HADDR[7:2]);
    @(posedge HCLK);
    #1;
    m_led = nled; m_pc = npc; m_ticks = nt;
    chk("led_out", 32'(led_out), 32'(m_led));
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic addr(input bit w, input logic [7:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w;
    HADDR = ($urandom() & 32'hFFFF_FF00) | 32'(a);
    HSIZE = 3'($urandom_range(0, 2));
    HPROT = 4'($urandom_range(0, 15));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr(1'b1, a); cycle();
    idle(); HWDATA = d; cycle();
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    addr(1'b0, a); cycle();
    idle();
    v = HRDATA;
    chk("rdata", HRDATA, 32'(model_rd(int'(a[7:2]))));
  endtask

  // Write immediately followed by a read of the same word
  task automatic wr_rd(input logic [7:0] a, input logic [31:0] d);
    addr(1'b1, a); cycle();
    HWDATA = d; addr(1'b0, a); cycle();
    idle();
    chk("b2b_rdata", HRDATA, 32'(model_rd(int'(a[7:2]))));
  endtask

  // Asynchronous reset between clock edges; checked before any edge
  task automatic async_reset();
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_pwm_cnt", 32'(dut.u_tb.pwm_cnt), 32'h0);
    chk("rst_presc_cnt", 32'(dut.u_tb.presc_cnt), 32'h0);
    chk("rst_phase", 32'(dut.u_tb.phase), 32'h0);
    model_clear();
    idle();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
  endtask

  logic [31:0] v;
  int hi, run, maxrun, ticks, idx;
  logic [31:0] d;

  initial begin
    HRESETn = 1'b0; HSEL = 0; HADDR = 0; HTRANS = 0; HSIZE = 3'd2; HPROT = 0;
    HWRITE = 0; HWDATA = 0; HREADY = 1'b1;
    model_clear();
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_led", 32'(led_out), 32'h0);
    HRESETn = 1'b1;

    // Reset state of every register and constant bus responses
    for (int i = 0; i < 12; i++) begin
      rd(8'(i * 4), v);
      chk("reset_reg", v, 32'h0);
    end
    chk("hreadyout", 32'(HREADYOUT), 32'h1);
    chk("hresp", 32'(HRESP), 32'h0);

    // Static output path
    wr(8'h00, 32'h1);
    wr(8'h04, 32'hA5);
    cycle();
    chk("static_led", 32'(led_out), 32'hA5);
    rd(8'h04, v);
    chk("out_rd", v, 32'h0000_00A5);

    // PWM with PRESC=0, DUTY[0]=64: 64 high cycles per 256-cycle period
    wr(8'h0C, 32'h0);
    wr(8'h08, 32'h01);
    wr(8'h10, 32'd64);
    wr(8'h00, 32'h1);
    for (int p = 0; p < 4; p++) begin
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        cycle();
        if (led_out[0]) hi++;
      end
      chk("pwm_period_hi", 32'(hi), 32'd64);
    end

    // Blink: every other period fully dark
    wr(8'h00, 32'h3);
    hi = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 1024; c++) begin
      cycle();
      if (led_out[0]) begin hi++; run = 0; end
      else begin run++; if (run > maxrun) maxrun = run; end
    end
    chk("blink_hi", 32'(hi), 32'd128);
    chk("blink_dark_run", 32'(maxrun), 32'd448);

    // Prescaler 3: tick every 4 cycles; DUTY[3]=9 -> 36 of 1024 cycles
    wr(8'h0C, 32'h3);
    wr(8'h1C, 32'd9);
    wr(8'h08, 32'h08);
    wr(8'h00, 32'h1);
    ticks = 0; hi = 0;
    for (int c = 0; c < 1024; c++) begin
      cycle();
      if (dut.u_tb.tick) ticks++;
      if (led_out[3]) hi++;
    end
    chk("presc_ticks", 32'(ticks), 32'd256);
    chk("presc_duty_hi", 32'(hi), 32'd36);
    rd(8'h1C, v);
    chk("duty3_rd", v, 32'd9);
    wr(8'hFC, 32'hFFFF_FFFF);
    rd(8'hFC, v);
    chk("unmapped_rd", v, 32'h0);
    rd(8'h1C, v);
    rd(8'h00, v);
    chk("ctrl_after_unmapped", v, 32'h1);

    // Randomized traffic against the model
    wr(8'h0C, 32'h0);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          idx = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 63) : $urandom_range(0, 11);
          d = $urandom();
          if (idx == 3) d = 32'($urandom_range(0, 3));
          if (idx == 0) d = {d[31:2], 1'b1, d[0]} ^ 32'($urandom_range(0, 1) * 2);
          if (idx == 0 && $urandom_range(0, 5) == 0) d[0] = 1'b0;
          wr(8'(idx * 4), d);
        end
        4, 5, 6: begin
          idx = $urandom_range(0, 15);
          rd(8'(idx * 4), v);
        end
        7: begin
          idx = $urandom_range(1, 11);
          if (idx == 3) wr_rd(8'h0C, 32'($urandom_range(0, 3)));
          else          wr_rd(8'(idx * 4), $urandom());
        end
        8: begin
          addr(1'b1, 8'(4 * $urandom_range(0, 11)));
          if ($urandom_range(0, 1) == 1) HSEL = 1'b0;
          else                           HTRANS = 2'b01;
          cycle();
          idle(); HWDATA = $urandom(); cycle();
        end
        default: begin
          idle();
          repeat ($urandom_range(1, 20)) cycle();
        end
      endcase
    end

    // Reset while PWM runs, with a write data phase in flight
    wr(8'h0C, 32'h0);
    wr(8'h08, 32'hFF);
    for (int i = 0; i < 8; i++) wr(8'(16 + 4 * i), 32'(32 * i + 16));
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h1);
    repeat (300) cycle();
    addr(1'b1, 8'h04); cycle();
    idle(); HWDATA = 32'hFF;
    async_reset();
    repeat (2) cycle();
    chk("post_rst_led", 32'(led_out), 32'h0);
    for (int i = 0; i < 12; i++) begin
      rd(8'(i * 4), v);
      chk("post_rst_reg", v, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
